dp_ram_stream_loader: RTL and testbench

Streaming write-side front end for the coprocessor's distributed dual-port RAM (parallel-read register file). It accepts a valid/ready word stream, writes a commanded number of words into consecutive RAM addresses starting at a base address (with wrap-around), and signals completion only once the last word is committed. The coprocessor datapath can then safely sample the RAM's parallel outputs.

---
 rtl/dp_ram_stream_loader.sv | 123 ++++++++++++
 tb/tb_dp_ram_stream_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_stream_loader.sv
// dp_ram_stream_loader
//   Write-side front end for the coprocessor's distributed dual-port RAM.
//   Accepts a valid/ready word stream and writes `count` words to consecutive
//   RAM addresses starting at `base_addr`, wrapping DEPTH-1 -> 0. `done`
//   pulses only once the last word has been captured by the RAM.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start               command strobe (IDLE only)
//   base_addr [AW-1:0]  first RAM address (< DEPTH)
//   count     [AW:0]    words to load, 0..DEPTH
//   s_valid/s_data      input word stream
//   s_ready             word accepted this cycle (LOAD)
//   ram_we/ram_w_addr/ram_di  registered RAM write port
//   busy                LOAD or DRAIN
//   done                one-cycle pulse, load complete
//   err                 one-cycle pulse, command rejected
module dp_ram_stream_loader #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      count,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             ram_we,
  output logic [AW-1:0]    ram_w_addr,
  output logic [WIDTH-1:0] ram_di,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [AW:0]      r_rem;
  logic             r_we, r_done, r_err;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_di;

  logic w_hs, w_cmd_zero, w_cmd_bad, w_cmd_ok, w_last;

  // A zero-length command completes trivially, regardless of base_addr.
  assign w_cmd_zero = (count == '0);
  assign w_cmd_bad  = (count > DEPTH_C) || ({1'b0, base_addr} >= DEPTH_C);
  assign w_cmd_ok   = !w_cmd_zero && !w_cmd_bad;
  assign w_hs       = s_valid && (r_state == S_LOAD);
  assign w_last     = w_hs && (r_rem == ONE_C);

  // Decoded from the state register only: no path from s_valid.
  assign s_ready    = (r_state == S_LOAD);
  assign busy       = (r_state != S_IDLE);
  assign ram_we     = r_we;
  assign ram_w_addr = r_addr;
  assign ram_di     = r_di;
  assign done       = r_done;
  assign err        = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start && w_cmd_ok) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_last)            w_state_nxt = S_DRAIN;
      S_DRAIN:                        w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_rem  <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_di   <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: if (start) begin
          if (w_cmd_zero)      r_done <= 1'b1;
          else if (w_cmd_bad)  r_err  <= 1'b1;
          else begin
            r_ptr <= base_addr;
            r_rem <= count;
          end
        end
        S_LOAD: if (w_hs) begin
          r_we   <= 1'b1;
          r_addr <= r_ptr;
          r_di   <= s_data;
          // Explicit wrap so non-power-of-two depths stay in range.
          r_ptr  <= (r_ptr == LAST_A) ? '0 : r_ptr + AW'(1);
          r_rem  <= r_rem - ONE_C;
        end
        // Final write is on the RAM port this cycle; it is captured at
        // the next edge, which is also when done goes high.
        S_DRAIN: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_ram_stream_loader.sv
// Bench for dp_ram_stream_loader: two instances (DEPTH=32 and DEPTH=24)
// share one stimulus stream; each has its own RAM model and expected
// write/event queues filled by the driver and drained by a monitor.
module tb_dp_ram_stream_loader;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          s_valid;
  logic [W-1:0]  s_data;

  logic a_ready, a_we, a_busy, a_done, a_err;
  logic b_ready, b_we, b_busy, b_done, b_err;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_di, b_di;

  always #5 clk = ~clk;

  dp_ram_stream_loader #(.WIDTH(W), .DEPTH(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .s_valid(s_valid), .s_data(s_data), .s_ready(a_ready),
    .ram_we(a_we), .ram_w_addr(a_addr), .ram_di(a_di), .busy(a_busy),
    .done(a_done), .err(a_err));

  dp_ram_stream_loader #(.WIDTH(W), .DEPTH(24)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .s_valid(s_valid), .s_data(s_data), .s_ready(b_ready),
    .ram_we(b_we), .ram_w_addr(b_addr), .ram_di(b_di), .busy(b_busy),
    .done(b_done), .err(b_err));

  // RAM models (no reset, capture on rising edge).
  logic [W-1:0] mem_a [32];
  logic [W-1:0] mem_b [24];
  always @(posedge clk) if (a_we) mem_a[a_addr] <= a_di;
  always @(posedge clk) if (b_we) mem_b[b_addr] <= b_di;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Scoreboards: writes are {addr, data}; events are {err, done}.
  logic [63:0] wq_a[$], wq_b[$];
  logic [1:0]  eq_a[$], eq_b[$];
  logic [63:0] ea, eb;

  always @(negedge clk) if (rst_n) begin
    if (a_we) begin
      if (wq_a.size() == 0) chk("a_we_unexp", a_we, 0);
      else begin
        ea = wq_a.pop_front();
        chk("a_waddr", a_addr, ea[63:32]);
        chk("a_wdata", a_di, ea[31:0]);
      end
    end
    if (a_done || a_err) begin
      if (eq_a.size() == 0) chk("a_ev_unexp", {a_err, a_done}, 0);
      else                  chk("a_ev", {a_err, a_done}, eq_a.pop_front());
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (b_we) begin
      if (wq_b.size() == 0) chk("b_we_unexp", b_we, 0);
      else begin
        eb = wq_b.pop_front();
        chk("b_waddr", b_addr, eb[63:32]);
        chk("b_wdata", b_di, eb[31:0]);
      end
    end
    if (b_done || b_err) begin
      if (eq_b.size() == 0) chk("b_ev_unexp", {b_err, b_done}, 0);
      else                  chk("b_ev", {b_err, b_done}, eq_b.pop_front());
    end
  end

  task automatic push_exp(input int base, input int cnt, input logic [31:0] d0,
                          output bit ok_a, output bit ok_b);
    ok_a = cnt >= 1 && cnt <= 32 && base < 32;
    ok_b = cnt >= 1 && cnt <= 24 && base < 24;
    if (cnt == 0)  eq_a.push_back(2'b01);
    else if (!ok_a) eq_a.push_back(2'b10);
    else begin
      eq_a.push_back(2'b01);
      for (int i = 0; i < cnt; i++) wq_a.push_back({32'((base + i) % 32), d0 + 32'(i)});
    end
    if (cnt == 0)  eq_b.push_back(2'b01);
    else if (!ok_b) eq_b.push_back(2'b10);
    else begin
      eq_b.push_back(2'b01);
      for (int i = 0; i < cnt; i++) wq_b.push_back({32'((base + i) % 24), d0 + 32'(i)});
    end
  endtask

  // Entered and left at a falling edge.
  task automatic run_cmd(input int base, input int cnt, input logic [15:0] vpat,
                         input logic [31:0] d0, input bit poke);
    bit ok_a, ok_b, hs;
    int sent, p;
    push_exp(base, cnt, d0, ok_a, ok_b);
    start = 1'b1; base_addr = AW'(base); count = (AW+1)'(cnt);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("a_busy", a_busy, ok_a);
    chk("b_busy", b_busy, ok_b);
    chk("a_done_nxt", a_done, cnt == 0);
    chk("b_done_nxt", b_done, cnt == 0);
    chk("a_err_nxt", a_err, cnt != 0 && !ok_a);
    chk("b_err_nxt", b_err, cnt != 0 && !ok_b);
    if (!ok_a && !ok_b) begin
      // Words offered while idle must be ignored.
      s_valid = 1'b1; s_data = d0;
      repeat (2) @(negedge clk);
      s_valid = 1'b0;
    end else begin
      sent = 0; p = 0;
      while (sent < cnt) begin
        s_valid = vpat[p % 16];
        s_data  = d0 + 32'(sent);
        if (poke && sent == 1) begin start = 1'b1; count = 1; base_addr = '0; end
        hs = s_valid && (a_ready || b_ready);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        if (hs) sent++;
        p++;
        if (p > 200) begin chk("timeout", sent, cnt); break; end
      end
      s_valid = 1'b0;
      if (ok_a) begin
        chk("a_drain_rdy", a_ready, 0); chk("a_drain_busy", a_busy, 1); chk("a_drain_done", a_done, 0);
      end
      if (ok_b) begin
        chk("b_drain_rdy", b_ready, 0); chk("b_drain_busy", b_busy, 1); chk("b_drain_done", b_done, 0);
      end
      @(posedge clk); @(negedge clk);
      if (ok_a) begin chk("a_done", a_done, 1); chk("a_idle", a_busy, 0); end
      if (ok_b) begin chk("b_done", b_done, 1); chk("b_idle", b_busy, 0); end
      @(posedge clk); @(negedge clk);
      if (ok_a) chk("a_done_1cyc", a_done, 0);
      if (ok_b) chk("b_done_1cyc", b_done, 0);
    end
    @(negedge clk);
    chk("a_wq_left", wq_a.size(), 0);
    chk("b_wq_left", wq_b.size(), 0);
    chk("a_eq_left", eq_a.size(), 0);
    chk("b_eq_left", eq_b.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok_a, ok_b, hs;
    int sent;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    chk("a_reset", {a_ready, a_we, a_addr, a_di, a_busy, a_done, a_err}, 0);
    chk("b_reset", {b_ready, b_we, b_addr, b_di, b_busy, b_done, b_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(0, 4, 16'hFFFF, 32'hA0, 1'b0);
    for (int i = 0; i < 4; i++) chk("a_mem_basic", mem_a[i], 32'hA0 + 32'(i));
    run_cmd(30, 4, 16'hFFFF, 32'hB0, 1'b0);   // A wraps 30,31,0,1; B rejects
    run_cmd(22, 3, 16'hFFFF, 32'hB8, 1'b0);   // B wraps 22,23,0
    chk("b_mem_wrap", mem_b[0], 32'hBA);
    run_cmd(4, 3, 16'h0029, 32'hD0, 1'b0);    // valid 1,0,0,1,0,1
    run_cmd(3, 0, 16'hFFFF, 32'h11, 1'b0);    // zero-length
    run_cmd(0, 33, 16'hFFFF, 32'h22, 1'b0);   // too long
    run_cmd(10, 4, 16'hFFFF, 32'hE0, 1'b1);   // start during LOAD ignored
    run_cmd(5, 32, 16'hFFFF, 32'h100, 1'b0);  // full load on A
    for (int i = 0; i < 32; i++) chk("a_mem_full", mem_a[(5 + i) % 32], 32'h100 + 32'(i));

    // Reset in the middle of an 8-word load after 3 words are committed.
    push_exp(0, 8, 32'hC0, ok_a, ok_b);
    start = 1'b1; base_addr = '0; count = 8;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    sent = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 50 && sent < 3; c++) begin
      s_data = 32'hC0 + 32'(sent);
      hs = s_valid && (a_ready || b_ready);
      @(posedge clk); @(negedge clk);
      if (hs) sent++;
    end
    chk("rst_hs", sent, 3);
    s_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("a_rst_mid", {a_ready, a_we, a_addr, a_di, a_busy, a_done, a_err}, 0);
    chk("b_rst_mid", {b_ready, b_we, b_addr, b_di, b_busy, b_done, b_err}, 0);
    wq_a.delete(); wq_b.delete(); eq_a.delete(); eq_b.delete();
    for (int i = 0; i < 3; i++) begin
      chk("a_mem_rst", mem_a[i], 32'hC0 + 32'(i));
      chk("b_mem_rst", mem_b[i], 32'hC0 + 32'(i));
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_cmd(7, 2, 16'hFFFF, 32'hF0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
